feature_window_loader: RTL

Upstream feeder for the drowsiness ANN (`DrowsinessDetector`). Accepts a serial stream of 10-bit eye-metric samples over a valid/ready handshake and maintains a 30-entry sliding window. It presents the window as the ANN's `in[0:29]` array and drives the ANN `Start` level. The window is frozen while the ANN evaluates, and each new launch follows a fixed hop of fresh samples.

---
 rtl/drowsy_pkg.sv | 16 +
 rtl/dropout_filter.sv | 35 +++
 rtl/feature_window_loader.sv | 93 +++++++++
 3 files changed

// File: rtl/drowsy_pkg.sv
// Shared types and constants for the drowsiness-detector front end.
package drowsy_pkg;

   localparam int ANN_IN_DEPTH = 30;
   localparam int SAMPLE_W     = 10;
   localparam int COUNT_W      = 8;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } loader_state_e;

endpackage

// File: rtl/dropout_filter.sv
// Replaces zero (tracker-loss) samples with the last non-zero accepted sample
// and counts substitutions with a saturating counter.
module dropout_filter
   import drowsy_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               accept,
   input  logic [WIDTH-1:0]   sample_in,
   output logic [WIDTH-1:0]   sample_out,
   output logic [COUNT_W-1:0] dropout_count
);

   logic [WIDTH-1:0] last_good;
   logic             is_zero;

   assign is_zero    = (sample_in == '0);
   assign sample_out = is_zero ? last_good : sample_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_good     <= '0;
         dropout_count <= '0;
      end else if (accept) begin
         if (!is_zero) begin
            last_good <= sample_in;
         end else if (dropout_count != {COUNT_W{1'b1}}) begin
            dropout_count <= dropout_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/feature_window_loader.sv
// Sliding-window feeder for the drowsiness ANN: FILL -> RUN -> GAP launch control.
// Define DROPOUT_FILL_EN to substitute zero samples with the last non-zero sample.
module feature_window_loader
   import drowsy_pkg::*;
#(
   parameter int DEPTH = ANN_IN_DEPTH,
   parameter int WIDTH = SAMPLE_W,
   parameter int HOP   = 10
) (
   input  logic               Clock,
   input  logic               Rst,
   input  logic [WIDTH-1:0]   sample_in,
   input  logic               sample_valid,
   output logic               sample_ready,
   input  logic               ann_done,
   output logic [WIDTH-1:0]   window [0:DEPTH-1],
   output logic               Start,
   output logic [COUNT_W-1:0] frame_count,
   output logic [COUNT_W-1:0] dropout_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   loader_state_e    state_q, state_d;
   logic [CNT_W-1:0] fill_cnt, hop_cnt;
   logic             xfer;
   logic [WIDTH-1:0] stored;

   // Ready is held low through reset so the source cannot push into a clearing window.
   assign sample_ready = Rst && (state_q != RUN);
   assign Start        = (state_q == RUN);
   assign xfer         = sample_valid && sample_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) state_q <= FILL;
      else      state_q <= state_d;
   end

   // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:    if (xfer && fill_cnt == CNT_W'(DEPTH - 1)) state_d = RUN;
         RUN:     if (ann_done) state_d = GAP;
         GAP:     if (xfer && hop_cnt == CNT_W'(HOP - 1)) state_d = RUN;
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         fill_cnt    <= '0;
         hop_cnt     <= '0;
         frame_count <= '0;
      end else begin
         if (state_q == FILL && xfer) fill_cnt <= fill_cnt + CNT_W'(1);
         if (state_q == RUN && ann_done) begin
            hop_cnt     <= '0;
            frame_count <= frame_count + COUNT_W'(1);
         end else if (state_q == GAP && xfer) begin
            hop_cnt <= hop_cnt + CNT_W'(1);
         end
      end
   end

   // NOTE: the window is a flop array feeding the ANN directly, so it is reset like any other state.
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < DEPTH; i++) window[i] <= '0;
      end else if (xfer) begin
         for (int i = 0; i < DEPTH - 1; i++) window[i] <= window[i+1];
         window[DEPTH-1] <= stored;
      end
   end

`ifdef DROPOUT_FILL_EN
   dropout_filter #(
      .WIDTH(WIDTH)
   ) u_dropout_filter (
      .clk          (Clock),
      .rst_n        (Rst),
      .accept       (xfer),
      .sample_in    (sample_in),
      .sample_out   (stored),
      .dropout_count(dropout_count)
   );
`else
   assign stored        = sample_in;
   assign dropout_count = '0;
`endif

endmodule
